// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the serial ALU sequencer and its shift registers.
package alu_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int OP_WIDTH      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_shift_reg.sv
// Parallel-load register that shifts right by one per enable, filling the MSB from serial_in.
module bit_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  // Load wins over shift so a new operation always starts from fresh operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {serial_in, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: streams operand bit pairs LSB first through an external
// logic-extender slice and assembles the slice's output bits into a held result.
module alu_serial_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    a_in,
  input  logic [WIDTH-1:0]    b_in,
  input  logic [OP_WIDTH-1:0] op_in,
  output logic                a_i,
  output logic                b_i,
  output logic                M,
  output logic                S1,
  output logic                S0,
  input  logic                x_i,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                zero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [OP_WIDTH-1:0] op_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    res_q;
  logic [WIDTH-1:0]    res_next;
  logic                accept;
  logic                shifting;
  logic                unused_bits;

  assign accept   = (state == IDLE) && start;
  assign shifting = (state == SHIFT);

  // The final slice bit is folded in directly so result is complete on entry to DONE.
  assign res_next = {x_i, res_q[WIDTH-1:1]};

  bit_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data (a_in),
    .shift_en  (shifting),
    .serial_in (1'b0),
    .q         (a_q)
  );

  bit_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data (b_in),
    .shift_en  (shifting),
    .serial_in (1'b0),
    .q         (b_q)
  );

  bit_shift_reg #(.WIDTH(WIDTH)) u_res_sr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data ('0),
    .shift_en  (shifting),
    .serial_in (x_i),
    .q         (res_q)
  );

  assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1], res_q[0]};

  // Slice drive is forced low outside SHIFT so the downstream slice sees a quiet bus.
  assign a_i          = shifting & a_q[0];
  assign b_i          = shifting & b_q[0];
  assign {M, S1, S0}  = shifting ? op_q : '0;

  // Sequencer FSM; result/zero only change on the last shift so partial results stay hidden.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= res_next;
            zero   <= (res_next == '0);
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer with the slice stubbed as x_i = a_i ^ b_i.
module tb_alu_serial_sequencer;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] expRes;
    logic         expZero;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [2:0]   op_in;
  logic         a_i, b_i, M, S1, S0;
  logic         x_i;
  logic         busy, done, zero;
  logic [W-1:0] result;

  int           checkCount = 0;
  int           errCount   = 0;
  exp_t         expQ[$];
  logic [W-1:0] lastResult;
  vec_t         vecs[8];

  always #5 clk = ~clk;

  assign x_i = a_i ^ b_i;

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .op_in  (op_in),
    .a_i    (a_i),
    .b_i    (b_i),
    .M      (M),
    .S1     (S1),
    .S0     (S0),
    .x_i    (x_i),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkSliceQuiet(input string name);
    checkOutput(name, {27'd0, a_i, b_i, M, S1, S0}, 32'd0);
  endtask

  // Scoreboard: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("sb_result", {24'd0, result}, {24'd0, e.res});
        checkOutput("sb_zero", {31'd0, zero}, {31'd0, e.z});
      end
    end
  end

  // Runs one operation from an IDLE negedge, checking every SHIFT cycle and the DONE cycle.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] op, input logic [W-1:0] expRes,
                               input logic expZero);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkSliceQuiet("idle_slice");
    a_in  = a;
    b_in  = b;
    op_in = op;
    start = 1'b1;
    expQ.push_back('{res: expRes, z: expZero});
    @(negedge clk);
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    op_in = ~op;
    for (int k = 0; k < W; k++) begin
      checkOutput("shift_busy", {31'd0, busy}, 32'd1);
      checkOutput("shift_done", {31'd0, done}, 32'd0);
      checkOutput("shift_ai", {31'd0, a_i}, {31'd0, a[k]});
      checkOutput("shift_bi", {31'd0, b_i}, {31'd0, b[k]});
      checkOutput("shift_op", {29'd0, M, S1, S0}, {29'd0, op});
      checkOutput("shift_result_held", {24'd0, result}, {24'd0, lastResult});
      @(negedge clk);
    end
    checkOutput("done_latency", {31'd0, done}, 32'd1);
    checkOutput("done_busy", {31'd0, busy}, 32'd0);
    checkSliceQuiet("done_slice");
    checkOutput("done_result", {24'd0, result}, {24'd0, expRes});
    @(negedge clk);
    checkOutput("done_single_pulse", {31'd0, done}, 32'd0);
    checkOutput("after_result_hold", {24'd0, result}, {24'd0, expRes});
    lastResult = expRes;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'h0F, 3'b101, 8'hAA, 1'b0};
    vecs[1] = '{8'h3C, 8'h3C, 3'b000, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 3'b111, 8'hFF, 1'b0};
    vecs[3] = '{8'h01, 8'h00, 3'b010, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h00, 3'b110, 8'h80, 1'b0};
    vecs[5] = '{8'h55, 8'hAA, 3'b001, 8'hFF, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 3'b011, 8'h26, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 3'b100, 8'h00, 1'b1};

    // Reset with start held high: start must be ignored.
    rst_n = 1'b0;
    start = 1'b1;
    a_in  = 8'hA5;
    b_in  = 8'h5A;
    op_in = 3'b111;
    lastResult = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_result", {24'd0, result}, 32'd0);
    checkOutput("rst_zero", {31'd0, zero}, 32'd1);
    checkSliceQuiet("rst_slice");
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("[TB] table-driven vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].expRes, vecs[i].expZero);
    end

    $display("[TB] start held high continuously");
    for (int c = 0; c < 40; c++) begin
      checkOutput("cont_busy", {31'd0, busy}, {31'd0, ((c % 10) >= 1 && (c % 10) <= 8)});
      checkOutput("cont_done", {31'd0, done}, {31'd0, ((c % 10) == 9)});
      start = 1'b1;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      op_in = 3'($urandom);
      if ((c % 10) == 0) begin
        expQ.push_back('{res: a_in ^ b_in, z: ((a_in ^ b_in) == '0)});
        lastResult = a_in ^ b_in;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("cont_end_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);

    $display("[TB] reset during SHIFT");
    applyStimulus(8'hF0, 8'h0F, 3'b011, 8'hFF, 1'b0);
    a_in  = 8'hC3;
    b_in  = 8'h00;
    op_in = 3'b110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_result", {24'd0, result}, 32'd0);
    checkOutput("abort_zero", {31'd0, zero}, 32'd1);
    checkSliceQuiet("abort_slice");
    lastResult = '0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      checkOutput("abort_no_done", {31'd0, done}, 32'd0);
    end

    applyStimulus(8'h81, 8'h18, 3'b101, 8'h99, 1'b0);
    repeat (2) @(negedge clk);

    checkOutput("scoreboard_empty", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule

// File: doc/alu_serial_sequencer.md
ALU_SERIAL_SEQUENCER -- requirements
Module: alu_serial_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation.
REQ-005 The block SHALL have port a_in, input, WIDTH, operand A.
REQ-006 The block SHALL have port b_in, input, WIDTH, operand B.
REQ-007 The block SHALL have port op_in, input, 3, operation select ordered {M,S1,S0}.
REQ-008 The block SHALL have ports a_i, b_i, output, 1 each, current operand bit pair driven to the downstream logic-extender slice.
REQ-009 The block SHALL have ports M, S1, S0, output, 1 each, mode/select driven to the slice.
REQ-010 The block SHALL have port x_i, input, 1, slice output bit, combinational from a_i/b_i/M/S1/S0 in the same cycle.
REQ-011 The block SHALL have ports busy and done, output, 1 each, and result, output, WIDTH, and zero, output, 1.

Function
REQ-012 The block SHALL implement states IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1, the block SHALL latch a_in, b_in, op_in, clear bit counter to 0, and enter SHIFT next cycle; start in SHIFT or DONE SHALL be ignored.
REQ-014 In SHIFT, a_i/b_i SHALL equal bit 0 of the internal A/B shift registers, and M/S1/S0 SHALL equal the latched op, stable for the whole operation.
REQ-015 Each SHIFT cycle, the block SHALL sample x_i into the result shift register MSB (shift right), shift A and B right by one, and increment the counter.
REQ-016 After exactly WIDTH SHIFT cycles (counter reaches WIDTH-1 and is sampled), the block SHALL enter DONE; bit k of result SHALL equal x_i sampled in SHIFT cycle k (LSB first).
REQ-017 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 for exactly the one DONE cycle, after which the block returns to IDLE.
REQ-018 result SHALL hold its last completed value from DONE until the next operation completes; intermediate shifting SHALL NOT be visible on result (separate shift and output registers).
REQ-019 zero SHALL be 1 when the held result is all zeros, updated with result.
REQ-020 In IDLE and DONE, a_i, b_i, M, S1, S0 SHALL be driven 0.
REQ-021 Latency start-accept to done SHALL be WIDTH+1 cycles; back-to-back throughput one operation per WIDTH+2 cycles.
REQ-022 The counter SHALL be ceil(log2(WIDTH)) bits and SHALL NOT wrap within an operation.

Reset
REQ-023 On rst_n=0 at a clock edge, the block SHALL enter IDLE and clear busy, done, result, shift registers, counter, latched op and all slice outputs to 0; zero SHALL be 1.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse and result=0.
REQ-025 start sampled in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-026 A shared package alu_seq_pkg SHALL hold the state enumeration, the default WIDTH constant and the 3-bit op field width.
REQ-027 One sub-module, bit_shift_reg (parallel-load, serial right shift, serial-in MSB), SHALL be instantiated for A, B and result shifting.

Verification (bench stub models slice as x_i = a_i XOR b_i, WIDTH=8)
REQ-028 Reset then start with A=8'hA5, B=8'h0F, op=3'b101 -> M/S1/S0=1/0/1 during SHIFT, done at cycle 9 after accept, result=8'hAA, zero=0.
REQ-029 A=8'h3C, B=8'h3C -> result=8'h00, zero=1, done single-cycle pulse.
REQ-030 start held high continuously -> operations accepted only in IDLE, done pulses every 10 cycles, busy never high during DONE.
REQ-031 rst_n low at SHIFT cycle 4 -> next cycle IDLE, busy=0, result=0, no done pulse.
REQ-032 Per-cycle check during SHIFT: a_i/b_i equal A[k]/B[k] for k=0..7 in order; all slice outputs 0 in IDLE.
